mss_cluster_scan: RTL
=====================

# mss_cluster_scan

Parametrised multi-cluster scan segment for the monolithic 3D JSCAN fabric: NUM_CLUSTERS independent CHAIN_LEN-bit scan chains, one routed to the serial scan path per command. A command handshake selects cluster and operation: counted shift, parallel capture, parallel update, or 1-bit bypass shift. It replaces the single free-running 8-bit chain segment with a controller-driven, length-exact, multi-tier block.

## Interface
- NUM_CLUSTERS, 4, number of independent chains (>=1)
- CHAIN_LEN, 8, bits per chain (>=2)
- LEN_W, 16, width of shift-count field
- CL_W, max(1, clog2(NUM_CLUSTERS)), cluster index width (derived)

- clk  in  1  clock; all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 SHIFT, 01 CAPTURE, 10 UPDATE, 11 BYPASS
- cmd_cluster  in  CL_W  target chain index
- cmd_len  in  LEN_W  shift cycles for SHIFT/BYPASS
- scan_in  in  1  serial data in
- scan_out  out  1  serial data out
- cap_data  in  NUM_CLUSTERS*CHAIN_LEN  parallel capture; cluster k at [k*CHAIN_LEN +: CHAIN_LEN]
- upd_data  out  NUM_CLUSTERS*CHAIN_LEN  update registers, same packing
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for an illegal cluster

## Operation
- Reset: state IDLE, all chains 0, all upd_data 0, bypass flop 0, latched op SHIFT, latched cluster 0, counter 0; cmd_ready=1, busy=0, done=0, err=0, scan_out=0.
- States: IDLE, SHIFT, CAPTURE, UPDATE, BYPASS, DONE.
- Acceptance: cmd_valid & cmd_ready in IDLE latches op, cluster and len; next state per op. cmd_valid in any other state is ignored.
- SHIFT: each cycle, chain[c] <= {chain[c][CHAIN_LEN-2:0], scan_in}, counter decrements. The cycle with counter==1 is the last shift, then DONE. Other chains hold.
- BYPASS: each cycle, bypass <= scan_in, with the same counting. No chain changes.
- cmd_len==0 for SHIFT/BYPASS: go directly to DONE, with zero shifts.
- CAPTURE: one cycle, chain[c] <= cap_data slice c, then DONE.
- UPDATE: one cycle, upd slice c <= chain[c], then DONE. upd_data changes only here.
- Illegal cluster (cmd_cluster >= NUM_CLUSTERS): the command is accepted, goes straight to DONE, modifies nothing, and err=1 with done.
- DONE: done=1 for one cycle, then IDLE.
- scan_out: bypass flop when the latched op is BYPASS, otherwise chain[latched cluster][CHAIN_LEN-1]. It is a mux of registers only, with no combinational path from scan_in, and is valid in every state.
- Reset mid-operation: immediately returns to reset values. A partial shift is lost.

## Timing
- Accept at edge T. For SHIFT with len N, shifts occur at edges T+1..T+N, done is high during the cycle after T+N, and cmd_ready is high one cycle after done.
- CAPTURE/UPDATE: the register updates at T+1, done is high after T+1, and the minimum command-to-command spacing is 3 cycles.
- scan_in is sampled at each shift edge. scan_out presents the MSB before each shift edge, so the first bit out is the prior MSB.
- Chain-through latency is CHAIN_LEN shifts; bypass latency is 1 shift.
- busy = !cmd_ready.

## Test plan
- Reset release: scan_out=0, upd_data=0, cmd_ready=1, busy=0.
- SHIFT, cluster 2, len 8, scan_in serial 1,0,1,1,0,0,1,0 → chain2=8'hB2. UPDATE, cluster 2 → upd_data[23:16]=8'hB2, other slices 0, done exactly once.
- CAPTURE, cluster 1, with cap_data slice=8'h5A; then SHIFT, cluster 1, len 8 → scan_out emits 0,1,0,1,1,0,1,0 MSB-first, and chain1 ends holding the shifted-in bits.
- BYPASS, len 4, scan_in 1,1,0,1 → scan_out lags scan_in by one shift edge; all chains are unchanged.
- SHIFT, len 0 → done on the cycle after accept and no state change. With NUM_CLUSTERS=3, cmd_cluster=3 → done+err pulse and nothing modified.
- reset_n low mid-SHIFT (after 3 of 8 shifts) → all chains 0 and state IDLE; cmd_valid held high during busy is not accepted until cmd_ready returns.

Source files
------------

// File: rtl/mss_cluster_scan_if.sv
// Command, serial-scan and parallel-data signals of one multi-cluster scan segment.
// The master side (controller or bench) issues commands; the scan segment is the slave.
interface mss_cluster_scan_if #(
  parameter int NUM_CLUSTERS = 4,
  parameter int CHAIN_LEN    = 8,
  parameter int LEN_W        = 16,
  parameter int CL_W         = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1
);
  logic                              cmd_valid;
  logic                              cmd_ready;
  logic [1:0]                        cmd_op;
  logic [CL_W-1:0]                   cmd_cluster;
  logic [LEN_W-1:0]                  cmd_len;
  logic                              scan_in;
  logic                              scan_out;
  logic [NUM_CLUSTERS*CHAIN_LEN-1:0] cap_data;
  logic [NUM_CLUSTERS*CHAIN_LEN-1:0] upd_data;
  logic                              busy;
  logic                              done;
  logic                              err;

  modport master (
    output cmd_valid, cmd_op, cmd_cluster, cmd_len, scan_in, cap_data,
    input  cmd_ready, scan_out, upd_data, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cluster, cmd_len, scan_in, cap_data,
    output cmd_ready, scan_out, upd_data, busy, done, err
  );
endinterface

// File: rtl/mss_cluster_scan.sv
// Multi-cluster JSCAN segment: NUM_CLUSTERS independent chains, one routed to the
// serial path per command (counted shift, capture, update or 1-bit bypass shift).
module mss_cluster_scan #(
  parameter int NUM_CLUSTERS = 4,
  parameter int CHAIN_LEN    = 8,
  parameter int LEN_W        = 16,
  parameter int CL_W         = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mss_cluster_scan_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CAPTURE, S_UPDATE, S_BYPASS, S_DONE
  } state_e;

  localparam logic [1:0] OP_SHIFT   = 2'b00;
  localparam logic [1:0] OP_CAPTURE = 2'b01;
  localparam logic [1:0] OP_UPDATE  = 2'b10;
  localparam logic [1:0] OP_BYPASS  = 2'b11;
  localparam logic [CL_W:0] NUM_CL  = (CL_W+1)'(NUM_CLUSTERS);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CL_W-1:0]  cluster_q, cluster_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             illegal;

  logic [NUM_CLUSTERS-1:0][CHAIN_LEN-1:0] chain_q;
  logic [NUM_CLUSTERS-1:0][CHAIN_LEN-1:0] upd_q;
  logic [NUM_CLUSTERS-1:0]                chain_msb;
  logic                                   bypass_q;
  logic                                   sel_msb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_SHIFT;
      cluster_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cluster_q <= cluster_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cluster_d     = cluster_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    bus.cmd_ready = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    illegal       = ({1'b0, bus.cmd_cluster} >= NUM_CL);
    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          cluster_d = bus.cmd_cluster;
          cnt_d     = bus.cmd_len;
          err_d     = illegal;
          // An out-of-range cluster is still accepted but only reports completion.
          if (illegal) begin
            state_d = S_DONE;
          end else begin
            unique case (bus.cmd_op)
              OP_SHIFT:   state_d = (bus.cmd_len == '0) ? S_DONE : S_SHIFT;
              OP_CAPTURE: state_d = S_CAPTURE;
              OP_UPDATE:  state_d = S_UPDATE;
              default:    state_d = (bus.cmd_len == '0) ? S_DONE : S_BYPASS;
            endcase
          end
        end
      end
      S_SHIFT, S_BYPASS: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == LEN_W'(1)) state_d = S_DONE;
      end
      S_CAPTURE, S_UPDATE: state_d = S_DONE;
      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
        err_d    = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    bus.busy = !bus.cmd_ready;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLUSTERS; gi++) begin : g_cluster
      logic sel;
      assign sel = (cluster_q == CL_W'(gi));

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          chain_q[gi] <= '0;
          upd_q[gi]   <= '0;
        end else begin
          if (sel && state_q == S_SHIFT)
            chain_q[gi] <= {chain_q[gi][CHAIN_LEN-2:0], bus.scan_in};
          else if (sel && state_q == S_CAPTURE)
            chain_q[gi] <= bus.cap_data[gi*CHAIN_LEN +: CHAIN_LEN];
          if (sel && state_q == S_UPDATE)
            upd_q[gi] <= chain_q[gi];
        end
      end

      assign bus.upd_data[gi*CHAIN_LEN +: CHAIN_LEN] = upd_q[gi];
      assign chain_msb[gi] = chain_q[gi][CHAIN_LEN-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                bypass_q <= 1'b0;
    else if (state_q == S_BYPASS) bypass_q <= bus.scan_in;
  end

  // Register-only mux; an out-of-range latched cluster reads as 0.
  always_comb begin
    sel_msb = 1'b0;
    for (int k = 0; k < NUM_CLUSTERS; k++)
      if (cluster_q == CL_W'(k)) sel_msb = chain_msb[k];
  end

  assign bus.scan_out = (op_q == OP_BYPASS) ? bypass_q : sel_msb;

endmodule
